// File: rtl/dmem_responder.sv
// Data-memory responder: word array with byte-lane writes, tohost MMIO word,
// out-of-range flagging and a fixed-latency in-order response pipeline.
module dmem_responder #(
    parameter int unsigned   DEPTH_WORDS = 4096,
    parameter logic [31:0]   BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned   LATENCY     = 1,             // legal range 1..4
    parameter logic [31:0]   TOHOST_ADDR = 32'h0000_1000,
    localparam int unsigned  XLEN        = 32,
    localparam int unsigned  ADDRW       = 32,
    localparam int unsigned  MASKW       = XLEN / 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dmem_valid_i,
    input  logic [ADDRW-1:0] dmem_addr_i,
    input  logic [MASKW-1:0] dmem_mask_i,
    input  logic [XLEN-1:0]  dmem_wdata_i,
    input  logic             dmem_we_i,
    output logic [XLEN-1:0]  dmem_rdata_o,
    output logic             dmem_rvalid_o,
    output logic             dmem_err_o,
    output logic [XLEN-1:0]  tohost_o
);

    localparam int unsigned IDXW = $clog2(DEPTH_WORDS);

    typedef struct packed {
        logic            rvalid;
        logic            err;
        logic [XLEN-1:0] rdata;
    } resp_t;

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] tohost_q;
    resp_t           pipe [LATENCY];

    logic            accept_c;
    logic            in_array_c;
    logic            is_tohost_c;
    logic [IDXW-1:0] idx_c;
    logic            unused_addr_lsb_c;

    // Request decode; BASE_ADDR is aligned to the array size so the upper bits select it.
    assign accept_c          = dmem_valid_i & ~rst_i;
    assign in_array_c        = (dmem_addr_i[ADDRW-1:IDXW+2] == BASE_ADDR[ADDRW-1:IDXW+2]);
    assign is_tohost_c       = (dmem_addr_i[ADDRW-1:2] == TOHOST_ADDR[ADDRW-1:2]);
    assign idx_c             = dmem_addr_i[IDXW+1:2];
    assign unused_addr_lsb_c = ^dmem_addr_i[1:0];

    // Byte-lane masked store into the array; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (accept_c && dmem_we_i && in_array_c) begin
            for (int i = 0; i < MASKW; i++) begin
                if (dmem_mask_i[i]) begin
                    mem[idx_c][8*i +: 8] <= dmem_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // tohost register with the same byte-lane merge rule.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tohost_q <= '0;
        end else if (accept_c && dmem_we_i && is_tohost_c) begin
            for (int i = 0; i < MASKW; i++) begin
                if (dmem_mask_i[i]) begin
                    tohost_q[8*i +: 8] <= dmem_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures the read, later stages shift every cycle.
    // rdata is only refreshed on loads so the output holds its last load value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe[s] <= '0;
            end
        end else begin
            pipe[0].rvalid <= accept_c & ~dmem_we_i;
            pipe[0].err    <= accept_c & ~in_array_c & ~is_tohost_c;
            if (accept_c && !dmem_we_i) begin
                if (in_array_c) begin
                    pipe[0].rdata <= mem[idx_c];
                end else if (is_tohost_c) begin
                    pipe[0].rdata <= tohost_q;
                end else begin
                    pipe[0].rdata <= '0;
                end
            end
            for (int s = 1; s < LATENCY; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    assign dmem_rvalid_o = pipe[LATENCY-1].rvalid;
    assign dmem_err_o    = pipe[LATENCY-1].err;
    assign dmem_rdata_o  = pipe[LATENCY-1].rdata;
    assign tohost_o      = tohost_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 2, 3) share one request
// stream; a scoreboard queue holds expected responses with their issue cycle.
module tb_dmem_responder;

    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    typedef struct {
        int          base;
        logic        rv;
        logic        er;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_i;
    logic        dmem_valid_i;
    logic [31:0] dmem_addr_i;
    logic [3:0]  dmem_mask_i;
    logic [31:0] dmem_wdata_i;
    logic        dmem_we_i;

    logic [31:0] rdata  [3];
    logic        rvalid [3];
    logic        err    [3];
    logic [31:0] tohost [3];

    int          lat [3] = '{1, 2, 3};
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 0;

    exp_t        sbq [$];
    int          rd_idx  [3];
    logic [31:0] last_rd [3];
    logic [31:0] mdl [int];
    logic [31:0] tohost_mdl;
    exp_t        mon_e;

    dmem_responder #(.LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_i(rst_i), .dmem_valid_i(dmem_valid_i), .dmem_addr_i(dmem_addr_i),
        .dmem_mask_i(dmem_mask_i), .dmem_wdata_i(dmem_wdata_i), .dmem_we_i(dmem_we_i),
        .dmem_rdata_o(rdata[0]), .dmem_rvalid_o(rvalid[0]), .dmem_err_o(err[0]), .tohost_o(tohost[0]));

    dmem_responder #(.LATENCY(2)) u_l2 (
        .clk_i(clk), .rst_i(rst_i), .dmem_valid_i(dmem_valid_i), .dmem_addr_i(dmem_addr_i),
        .dmem_mask_i(dmem_mask_i), .dmem_wdata_i(dmem_wdata_i), .dmem_we_i(dmem_we_i),
        .dmem_rdata_o(rdata[1]), .dmem_rvalid_o(rvalid[1]), .dmem_err_o(err[1]), .tohost_o(tohost[1]));

    dmem_responder #(.LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_i(rst_i), .dmem_valid_i(dmem_valid_i), .dmem_addr_i(dmem_addr_i),
        .dmem_mask_i(dmem_mask_i), .dmem_wdata_i(dmem_wdata_i), .dmem_we_i(dmem_we_i),
        .dmem_rdata_o(rdata[2]), .dmem_rvalid_o(rvalid[2]), .dmem_err_o(err[2]), .tohost_o(tohost[2]));

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: counts it and reports a failure with observed/expected.
    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s L%0d observed=%h expected=%h", tag, lat[d], obs, exp);
        end
    endtask

    // Drive one cycle of request; push the expected response, update the model at the edge.
    task automatic req(input logic vld, input logic we, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] wd);
        logic        arr;
        logic        th;
        int          idx;
        exp_t        e;
        logic [31:0] w;
        @(negedge clk);
        #1;
        dmem_valid_i = vld;
        dmem_we_i    = we;
        dmem_addr_i  = a;
        dmem_mask_i  = m;
        dmem_wdata_i = wd;
        arr = (a[31:14] == BASE[31:14]);
        th  = (a[31:2] == TOHOST[31:2]);
        idx = int'(a[13:2]);
        if (vld && (!we || !(arr || th))) begin
            e.base = cyc;
            e.rv   = !we;
            e.er   = !(arr || th);
            if (th)       e.data = tohost_mdl;
            else if (arr) e.data = mdl.exists(idx) ? mdl[idx] : 32'h0;
            else          e.data = 32'h0;
            sbq.push_back(e);
        end
        @(posedge clk);
        if (vld && we && (arr || th)) begin
            if (th) w = tohost_mdl;
            else    w = mdl.exists(idx) ? mdl[idx] : 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (m[i]) w[8*i +: 8] = wd[8*i +: 8];
            end
            if (th) tohost_mdl = w;
            else    mdl[idx] = w;
        end
    endtask

    // Reset for one edge with a store presented on the reset edge (must be ignored).
    task automatic do_reset(input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        #1;
        rst_i        = 1'b1;
        dmem_valid_i = 1'b1;
        dmem_we_i    = 1'b1;
        dmem_addr_i  = a;
        dmem_mask_i  = 4'hF;
        dmem_wdata_i = wd;
        for (int d = 0; d < 3; d++) begin
            rd_idx[d]  = sbq.size();
            last_rd[d] = 32'h0;
        end
        @(posedge clk);
        tohost_mdl = 32'h0;
        mon_en     = 1'b1;
        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_rvalid", d, 32'(rvalid[d]), 32'h0);
            chk("rst_err",    d, 32'(err[d]),    32'h0);
            chk("rst_rdata",  d, rdata[d],       32'h0);
            chk("rst_tohost", d, tohost[d],      32'h0);
        end
        rst_i        = 1'b0;
        dmem_valid_i = 1'b0;
    endtask

    // Monitor: every cycle each instance either delivers its next expected response or stays quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (rd_idx[d] < sbq.size() && sbq[rd_idx[d]].base + lat[d] == cyc) begin
                    mon_e = sbq[rd_idx[d]];
                    rd_idx[d]++;
                    chk("rvalid", d, 32'(rvalid[d]), 32'(mon_e.rv));
                    chk("err",    d, 32'(err[d]),    32'(mon_e.er));
                    if (mon_e.rv) begin
                        chk("rdata", d, rdata[d], mon_e.data);
                        last_rd[d] = mon_e.data;
                    end else begin
                        chk("rdata_hold", d, rdata[d], last_rd[d]);
                    end
                end else begin
                    chk("idle_rvalid", d, 32'(rvalid[d]), 32'h0);
                    chk("idle_err",    d, 32'(err[d]),    32'h0);
                    chk("rdata_hold",  d, rdata[d],       last_rd[d]);
                end
                chk("tohost", d, tohost[d], tohost_mdl);
            end
        end
    end

    // Directed sequence.
    initial begin
        rst_i        = 1'b0;
        dmem_valid_i = 1'b0;
        dmem_we_i    = 1'b0;
        dmem_addr_i  = 32'h0;
        dmem_mask_i  = 4'h0;
        dmem_wdata_i = 32'h0;
        tohost_mdl   = 32'h0;
        for (int d = 0; d < 3; d++) begin
            rd_idx[d]  = 0;
            last_rd[d] = 32'h0;
        end

        do_reset(32'h0001_0008, 32'h0);

        // Store then load the same word on the next cycle.
        req(1, 1, 32'h0001_0008, 4'hF, 32'hDEAD_BEEF);
        req(1, 0, 32'h0001_0008, 4'hF, 32'h0);

        // Byte merge and zero-mask store.
        req(1, 1, 32'h0001_0010, 4'hF, 32'h1122_3344);
        req(1, 1, 32'h0001_0010, 4'b0010, 32'h0000_AB00);
        req(1, 0, 32'h0001_0010, 4'h0, 32'h0);
        req(1, 1, 32'h0001_0010, 4'b0000, 32'hFFFF_FFFF);
        req(1, 0, 32'h0001_0010, 4'hF, 32'h0);

        // Fill four words, then read them back-to-back.
        for (int i = 0; i < 4; i++) req(1, 1, 32'h0001_0000 + 32'(4*i), 4'hF, 32'hA0A0_0000 + 32'(i));
        for (int i = 0; i < 4; i++) req(1, 0, 32'h0001_0000 + 32'(4*i), 4'hF, 32'h0);

        // Out-of-range load and store; the store must not alias into word 0.
        req(1, 0, 32'h0000_0004, 4'hF, 32'h0);
        req(1, 1, 32'h0002_0000, 4'hF, 32'h5555_5555);
        req(1, 0, 32'h0001_0000, 4'hF, 32'h0);

        // tohost store, readback, and a single-byte update.
        req(1, 1, 32'h0000_1000, 4'hF, 32'h0000_0001);
        req(1, 0, 32'h0000_1000, 4'hF, 32'h0);
        req(1, 1, 32'h0000_1000, 4'b0100, 32'h00AA_0000);
        req(1, 0, 32'h0000_1000, 4'hF, 32'h0);

        // Idle cycles with we held high must not write or respond.
        for (int i = 0; i < 3; i++) req(0, 1, 32'h0001_0008, 4'hF, 32'h1234_5678);
        req(1, 0, 32'h0001_0008, 4'hF, 32'h0);

        // Reset with loads in flight; a store on the reset edge is ignored.
        req(1, 0, 32'h0001_0000, 4'hF, 32'h0);
        req(1, 0, 32'h0001_0004, 4'hF, 32'h0);
        do_reset(32'h0001_0008, 32'hBADB_ADBA);
        for (int i = 0; i < 4; i++) req(0, 0, 32'h0, 4'h0, 32'h0);
        req(1, 0, 32'h0001_0008, 4'hF, 32'h0);
        req(1, 0, 32'h0000_1000, 4'hF, 32'h0);

        // Drain and confirm every expected response was delivered.
        for (int i = 0; i < 6; i++) req(0, 0, 32'h0, 4'h0, 32'h0);
        for (int d = 0; d < 3; d++) chk("drain", d, 32'(rd_idx[d]), 32'(sbq.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
